dm_line_server: RTL and testbench

//  Memory-side responder for the data-cache refill interface. Accepts one line-refill request at a time.

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_word_ram.sv | 21 ++
 rtl/dm_line_server.sv | 141 ++++++++++++++
 tb/tb_dm_line_server.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory side of the cache refill path.
package mem_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} line_srv_state_t;

    // Byte address to word index; callers truncate to their storage depth.
    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction
endpackage

// File: rtl/mem_word_ram.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module mem_word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [WORD_W-1:0]              i_wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
    output logic [WORD_W-1:0]              o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dm_line_server.sv
// Refill responder: fixed-latency, critical-word-first line bursts over valid/ready,
// plus a never-stalling write-through store port into the same storage.
module dm_line_server
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LINE_WORDS  = 4,
    parameter int LATENCY     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [WORD_W-1:0]             resp_data,
    output logic [$clog2(LINE_WORDS)-1:0] resp_beat,
    output logic                          resp_last,
    input  logic                          wr_en,
    input  logic [31:0]                   wr_addr,
    input  logic [WORD_W-1:0]             wr_data,
    output logic                          busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int HI_W  = IDX_W - OFF_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    line_srv_state_t   r_state, w_state_nx;
    logic [HI_W-1:0]   r_hi;
    logic [OFF_W-1:0]  r_off;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_resp_valid, r_resp_last;
    logic [WORD_W-1:0] r_resp_data;
    logic [OFF_W-1:0]  r_resp_beat;

    logic [IDX_W-1:0]  w_req_idx, w_wr_idx, w_ld_idx;
    logic [HI_W-1:0]   w_ld_hi;
    logic [OFF_W-1:0]  w_ld_off, w_start_off;
    logic              w_load, w_done, w_ld_last;
    logic [WORD_W-1:0] w_rd_data, w_ld_data;

    assign w_req_idx = IDX_W'(word_idx(req_addr));
    assign w_wr_idx  = IDX_W'(word_idx(wr_addr));

    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_ld_hi     = r_hi;
        w_ld_off    = r_resp_beat + OFF_W'(1);
        w_start_off = r_off;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_ld_hi     = w_req_idx[IDX_W-1:OFF_W];
                    w_ld_off    = w_req_idx[OFF_W-1:0];
                    w_start_off = w_req_idx[OFF_W-1:0];
                    if (LATENCY > 1) begin
                        w_state_nx = S_WAIT;
                    end else begin
                        w_load     = 1'b1;
                        w_state_nx = S_BURST;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_ld_off   = r_off;
                    w_load     = 1'b1;
                    w_state_nx = S_BURST;
                end
            end
            S_BURST: begin
                if (r_resp_valid && resp_ready) begin
                    if (r_resp_last) begin
                        w_done     = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Offset wraps inside the line, so the last beat sits just before the start offset.
    assign w_ld_idx  = {w_ld_hi, w_ld_off};
    assign w_ld_last = (w_ld_off == w_start_off - OFF_W'(1));
    assign w_ld_data = (wr_en && (w_wr_idx == w_ld_idx)) ? wr_data : w_rd_data;

    mem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk    (clk),
        .i_we   (wr_en),
        .i_waddr(w_wr_idx),
        .i_wdata(wr_data),
        .i_raddr(w_ld_idx),
        .o_rdata(w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_hi         <= '0;
            r_off        <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_beat  <= '0;
            r_resp_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_IDLE && req_valid) begin
                r_hi  <= w_ld_hi;
                r_off <= w_ld_off;
                r_cnt <= CNT_W'(LATENCY - 1);
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_load) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= w_ld_data;
                r_resp_beat  <= w_ld_off;
                r_resp_last  <= w_ld_last;
            end else if (w_done) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_beat  = r_resp_beat;
    assign resp_last  = r_resp_last;
endmodule

// File: tb/tb_dm_line_server.sv
// Directed bench for dm_line_server: latency, wrap order, back-pressure, forwarding, reset, address wrap.
module tb_dm_line_server;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_last;
    logic        wr_en, busy;
    logic [31:0] req_addr, resp_data, wr_addr, wr_data;
    logic [1:0]  resp_beat;
    int          total = 0;
    int          bad = 0;
    int          hs = 0;
    int          h0;

    dm_line_server #(.DEPTH_WORDS(1024), .LINE_WORDS(4), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_beat(resp_beat), .resp_last(resp_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (resp_valid === 1'b1 && resp_ready === 1'b1) hs <= hs + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Checks the beat currently presented, then advances one cycle.
    task automatic beat(input string tag, input logic [31:0] d, input logic [31:0] b, input logic l);
        chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_data"}, resp_data, d);
        chk({tag, "_beat"}, {30'd0, resp_beat}, b);
        chk({tag, "_last"}, {31'd0, resp_last}, {31'd0, l});
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Issues a request and leaves the bench at the cycle the first beat appears.
    task automatic req(input string tag, input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_lat"}, {31'd0, resp_valid}, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_beat", {30'd0, resp_beat}, 32'd0);
        chk("rst_last", {31'd0, resp_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        store(32'h20, 32'hA0); store(32'h24, 32'hA1);
        store(32'h28, 32'hA2); store(32'h2C, 32'hA3);

        // Aligned line, full latency observed cycle by cycle
        resp_ready = 1'b1; req_addr = 32'h20; req_valid = 1'b1;
        chk("t1_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_req_ready_busy", {31'd0, req_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("t1_lat", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        beat("t1_b0", 32'hA0, 0, 1'b0); beat("t1_b1", 32'hA1, 1, 1'b0);
        beat("t1_b2", 32'hA2, 2, 1'b0); beat("t1_b3", 32'hA3, 3, 1'b1);
        chk("t1_done_ready", {31'd0, req_ready}, 32'd1);
        chk("t1_done_valid", {31'd0, resp_valid}, 32'd0);
        chk("t1_done_busy", {31'd0, busy}, 32'd0);

        // Critical word first with wrap
        req("t2", 32'h28);
        beat("t2_b0", 32'hA2, 2, 1'b0); beat("t2_b1", 32'hA3, 3, 1'b0);
        beat("t2_b2", 32'hA0, 0, 1'b0); beat("t2_b3", 32'hA1, 1, 1'b1);
        chk("t2_done_ready", {31'd0, req_ready}, 32'd1);

        // Back-pressure on the second beat
        h0 = hs;
        req("t3", 32'h20);
        beat("t3_b0", 32'hA0, 0, 1'b0);
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("t3_stall_data", resp_data, 32'hA1);
            chk("t3_stall_beat", {30'd0, resp_beat}, 32'd1);
            tick();
        end
        resp_ready = 1'b1;
        beat("t3_b1", 32'hA1, 1, 1'b0); beat("t3_b2", 32'hA2, 2, 1'b0);
        beat("t3_b3", 32'hA3, 3, 1'b1);
        chk("t3_handshakes", hs - h0, 32'd4);
        chk("t3_done_valid", {31'd0, resp_valid}, 32'd0);

        // Store in the same cycle as the beat-1 load is forwarded
        req("t4a", 32'h20);
        wr_en = 1'b1; wr_addr = 32'h24; wr_data = 32'hDEAD;
        beat("t4a_b0", 32'hA0, 0, 1'b0);
        wr_en = 1'b0;
        beat("t4a_b1", 32'hDEAD, 1, 1'b0); beat("t4a_b2", 32'hA2, 2, 1'b0);
        beat("t4a_b3", 32'hA3, 3, 1'b1);
        store(32'h24, 32'hA1);

        // Store after the load leaves the loaded beat untouched
        req("t4b", 32'h20);
        beat("t4b_b0", 32'hA0, 0, 1'b0);
        resp_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 32'h24; wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("t4b_snapshot", resp_data, 32'hA1);
        resp_ready = 1'b1;
        beat("t4b_b1", 32'hA1, 1, 1'b0); beat("t4b_b2", 32'hA2, 2, 1'b0);
        beat("t4b_b3", 32'hA3, 3, 1'b1);
        req("t4c", 32'h24);
        beat("t4c_b0", 32'hDEAD, 1, 1'b0); beat("t4c_b1", 32'hA2, 2, 1'b0);
        beat("t4c_b2", 32'hA3, 3, 1'b0); beat("t4c_b3", 32'hA0, 0, 1'b1);
        store(32'h24, 32'hA1);

        // Reset mid-burst; a store during reset still lands
        req("t5", 32'h20);
        beat("t5_b0", 32'hA0, 0, 1'b0);
        chk("t5_b1_data", resp_data, 32'hA1);
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 32'h30; wr_data = 32'hB0;
        tick();
        wr_en = 1'b0;
        chk("t5_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_data", resp_data, 32'd0);
        rst = 1'b1;
        chk("t5_req_ready", {31'd0, req_ready}, 32'd1);
        tick(); tick();
        chk("t5_no_beats", {31'd0, resp_valid}, 32'd0);
        req("t5r", 32'h20);
        beat("t5r_b0", 32'hA0, 0, 1'b0); beat("t5r_b1", 32'hA1, 1, 1'b0);
        beat("t5r_b2", 32'hA2, 2, 1'b0); beat("t5r_b3", 32'hA3, 3, 1'b1);
        req("t5s", 32'h30);
        beat("t5s_b0", 32'hB0, 0, 1'b0);
        tick(); tick();
        chk("t5s_last_beat", {30'd0, resp_beat}, 32'd3);
        chk("t5s_last", {31'd0, resp_last}, 32'd1);
        tick();
        chk("t5s_done_ready", {31'd0, req_ready}, 32'd1);

        // Address wrap modulo depth; request pulsed during wait is ignored
        h0 = hs;
        req_addr = 32'h0000_1020; req_valid = 1'b1;
        tick();
        req_addr = 32'h28;
        chk("t6_ignored_ready", {31'd0, req_ready}, 32'd0);
        tick();
        req_valid = 1'b0;
        tick(); tick();
        beat("t6_b0", 32'hA0, 0, 1'b0); beat("t6_b1", 32'hA1, 1, 1'b0);
        beat("t6_b2", 32'hA2, 2, 1'b0); beat("t6_b3", 32'hA3, 3, 1'b1);
        tick(); tick();
        chk("t6_quiet_valid", {31'd0, resp_valid}, 32'd0);
        chk("t6_quiet_busy", {31'd0, busy}, 32'd0);
        chk("t6_handshakes", hs - h0, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
